// File: rtl/dmem_arbiter_if.sv
// Bundle of the core-side request ports and the shared data-memory port.
// The arbiter takes the master view; cores and memory together take the slave view.
interface dmem_arbiter_if #(
    parameter int NUM_CORE       = 4,
    parameter int REG_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH = 12
);
  localparam int BYTES_PER_REG = REG_WIDTH / 8;
  localparam int ID_W          = $clog2(NUM_CORE);

  logic [NUM_CORE*MEM_ADDR_WIDTH-1:0] core_addr;
  logic [NUM_CORE-1:0]                core_rd_en;
  logic [NUM_CORE-1:0]                core_wr_en;
  logic [NUM_CORE*REG_WIDTH-1:0]      core_wr_data;
  logic [NUM_CORE*BYTES_PER_REG-1:0]  core_wr_ben;
  logic [NUM_CORE-1:0]                core_rd_ack;
  logic [NUM_CORE-1:0]                core_wr_ack;
  logic [REG_WIDTH-1:0]               core_rd_data;

  logic [MEM_ADDR_WIDTH-1:0]          dmem_addr;
  logic                               dmem_rd_en;
  logic                               dmem_wr_en;
  logic [REG_WIDTH-1:0]               dmem_wr_data;
  logic [BYTES_PER_REG-1:0]           dmem_wr_ben;
  logic                               dmem_rd_ack;
  logic [REG_WIDTH-1:0]               dmem_rd_data;
  logic                               dmem_wr_ack;

  logic [ID_W-1:0]                    grant_id;
  logic                               busy;

  modport master (
    input  core_addr, core_rd_en, core_wr_en, core_wr_data, core_wr_ben,
    output core_rd_ack, core_wr_ack, core_rd_data,
    output dmem_addr, dmem_rd_en, dmem_wr_en, dmem_wr_data, dmem_wr_ben,
    input  dmem_rd_ack, dmem_rd_data, dmem_wr_ack,
    output grant_id, busy
  );

  modport slave (
    output core_addr, core_rd_en, core_wr_en, core_wr_data, core_wr_ben,
    input  core_rd_ack, core_wr_ack, core_rd_data,
    input  dmem_addr, dmem_rd_en, dmem_wr_en, dmem_wr_data, dmem_wr_ben,
    output dmem_rd_ack, dmem_rd_data, dmem_wr_ack,
    input  grant_id, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port among NUM_CORE cores: one outstanding transaction,
// round-robin or fixed-priority grant, registered memory request, combinational ack return.
module dmem_arbiter #(
    parameter int NUM_CORE       = 4,
    parameter int REG_WIDTH      = 32,
    parameter int MEM_ADDR_WIDTH = 12,
    parameter int ARB_MODE       = 0
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.master bus
);
  localparam int BYTES_PER_REG = REG_WIDTH / 8;
  localparam int ID_W          = $clog2(NUM_CORE);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t                    state_reg, state_next;
  logic [NUM_CORE-1:0]       req;
  logic                      any_req;
  logic [ID_W-1:0]           win;
  logic [ID_W-1:0]           last_reg;
  logic [ID_W-1:0]           grant_reg;
  logic                      op_wr_reg;
  logic                      match;
  logic [MEM_ADDR_WIDTH-1:0] addr_reg;
  logic                      rd_en_reg;
  logic                      wr_en_reg;
  logic [REG_WIDTH-1:0]      wr_data_reg;
  logic [BYTES_PER_REG-1:0]  wr_ben_reg;

  for (genvar gi = 0; gi < NUM_CORE; gi++) begin : g_req
    assign req[gi] = bus.core_rd_en[gi] | bus.core_wr_en[gi];
  end

  // Both loops run from the least to the most preferred candidate so the last hit wins.
  always_comb begin
    win     = '0;
    any_req = |req;
    if (ARB_MODE == 1) begin
      for (int i = NUM_CORE - 1; i >= 0; i--) begin
        if (req[ID_W'(i)]) win = ID_W'(i);
      end
    end else begin
      for (int k = NUM_CORE; k >= 1; k--) begin
        if (req[ID_W'((int'(last_reg) + k) % NUM_CORE)])
          win = ID_W'((int'(last_reg) + k) % NUM_CORE);
      end
    end
  end

  assign match = (state_reg == BUSY) && (op_wr_reg ? bus.dmem_wr_ack : bus.dmem_rd_ack);

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (any_req) state_next = BUSY;
      BUSY:    if (match)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bus.core_rd_ack = '0;
    bus.core_wr_ack = '0;
    if (match) begin
      if (op_wr_reg) bus.core_wr_ack[grant_reg] = 1'b1;
      else           bus.core_rd_ack[grant_reg] = 1'b1;
    end
  end

  // Request datapath: captured once at grant, held untouched until the matching ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg    <= '0;
      rd_en_reg   <= 1'b0;
      wr_en_reg   <= 1'b0;
      wr_data_reg <= '0;
      wr_ben_reg  <= '0;
      op_wr_reg   <= 1'b0;
      grant_reg   <= '0;
      last_reg    <= ID_W'(NUM_CORE - 1);
    end else if (state_reg == IDLE && any_req) begin
      addr_reg    <= bus.core_addr[int'(win)*MEM_ADDR_WIDTH +: MEM_ADDR_WIDTH];
      wr_data_reg <= bus.core_wr_data[int'(win)*REG_WIDTH +: REG_WIDTH];
      wr_ben_reg  <= bus.core_wr_ben[int'(win)*BYTES_PER_REG +: BYTES_PER_REG];
      op_wr_reg   <= bus.core_wr_en[win];
      wr_en_reg   <= bus.core_wr_en[win];
      rd_en_reg   <= ~bus.core_wr_en[win];
      grant_reg   <= win;
      last_reg    <= win;
    end else if (match) begin
      rd_en_reg <= 1'b0;
      wr_en_reg <= 1'b0;
    end
  end

  assign bus.dmem_addr    = addr_reg;
  assign bus.dmem_rd_en   = rd_en_reg;
  assign bus.dmem_wr_en   = wr_en_reg;
  assign bus.dmem_wr_data = wr_data_reg;
  assign bus.dmem_wr_ben  = wr_ben_reg;
  assign bus.core_rd_data = bus.dmem_rd_data;
  assign bus.grant_id     = grant_reg;
  assign bus.busy         = (state_reg == BUSY);
endmodule
